// File: rtl/mem_pkg.sv
// Shared types and widths for the data-memory responder and its storage array.
package mem_pkg;
  localparam int DATA_W    = 16;
  localparam int ADDR_BITS = 16;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_e;
endpackage

// File: rtl/mem_array.sv
// Single-port word storage: synchronous write, registered read, contents never reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int IDX_W = 7
) (
  input  logic              Clock,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [IDX_W-1:0]  raddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**IDX_W];

  always_ff @(posedge Clock) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/mem_responder.sv
// Load/store responder: one transaction at a time, WAIT_CYCLES wait states, address error flagging.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high; valid holds its payload until then.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  input  logic                 ReqValid,
  output logic                 ReqReady,
  input  logic                 ReqWrite,
  input  logic [ADDR_BITS-1:0] ReqAddr,
  input  logic [DATA_W-1:0]    ReqWData,
  output logic                 RespValid,
  input  logic                 RespReady,
  output logic [DATA_W-1:0]    RespRData,
  output logic                 RespErr,
  output logic                 Busy
);
  localparam int IDX_W = ADDR_W - 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  mem_state_e state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic                 write_q;
  logic                 resp_valid_q, resp_err_q, resp_load_q;

  logic                 accept, commit, addr_err, cur_write, we;
  logic [ADDR_BITS-1:0] cur_addr;
  logic [DATA_W-1:0]    cur_wdata;
  logic [DATA_W-1:0]    arr_rdata;

  // With zero wait states the commit edge is the acceptance edge, so decode straight from the request.
  assign cur_addr  = (state_q == IDLE) ? ReqAddr  : addr_q;
  assign cur_wdata = (state_q == IDLE) ? ReqWData : wdata_q;
  assign cur_write = (state_q == IDLE) ? ReqWrite : write_q;
  assign addr_err  = cur_addr[0] | (|cur_addr[ADDR_BITS-1:ADDR_W]);

  assign ReqReady  = (state_q == IDLE) & Reset_n;
  assign Busy      = (state_q != IDLE);
  assign accept    = ReqValid & ReqReady;
  assign we        = commit & cur_write & ~addr_err;
  assign RespValid = resp_valid_q;
  assign RespErr   = resp_err_q;
  assign RespRData = resp_load_q ? arr_rdata : '0;

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        if (WAIT_CYCLES == 0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: if (cnt_q == '0) begin
        state_d = RESP;
        commit  = 1'b1;
      end
      RESP: if (RespReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q   <= CNT_INIT;
        addr_q  <= ReqAddr;
        wdata_q <= ReqWData;
        write_q <= ReqWrite;
      end else if (state_q == WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      // The array read lands in arr_rdata on the commit edge; raddr stays on addr_q through RESP.
      if (commit) begin
        resp_valid_q <= 1'b1;
        resp_err_q   <= addr_err;
        resp_load_q  <= ~cur_write & ~addr_err;
      end else if (state_q == RESP && RespReady) begin
        resp_valid_q <= 1'b0;
        resp_err_q   <= 1'b0;
        resp_load_q  <= 1'b0;
      end
    end
  end

  mem_array #(.IDX_W(IDX_W)) u_array (
    .Clock (Clock),
    .we    (we),
    .waddr (cur_addr[IDX_W:1]),
    .raddr (cur_addr[IDX_W:1]),
    .wdata (cur_wdata),
    .rdata (arr_rdata)
  );
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_mem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WAIT_CYCLES=2 instance
  logic v2 = 0, wr2 = 0, rr2 = 0;
  logic [15:0] a2 = 0, wd2 = 0;
  logic rdy2, rv2, er2, bz2;
  logic [15:0] rd2;
  // WAIT_CYCLES=0 instance
  logic v0 = 0, wr0 = 0, rr0 = 0;
  logic [15:0] a0 = 0, wd0 = 0;
  logic rdy0, rv0, er0, bz0;
  logic [15:0] rd0;

  int tests = 0;
  int fails = 0;
  logic [16:0] exp_q[$];
  logic [15:0] model [int];

  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut2 (
    .Clock(clk), .Reset_n(rst_n), .ReqValid(v2), .ReqReady(rdy2), .ReqWrite(wr2),
    .ReqAddr(a2), .ReqWData(wd2), .RespValid(rv2), .RespReady(rr2),
    .RespRData(rd2), .RespErr(er2), .Busy(bz2));

  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
    .Clock(clk), .Reset_n(rst_n), .ReqValid(v0), .ReqReady(rdy0), .ReqWrite(wr0),
    .ReqAddr(a0), .ReqWData(wd0), .RespValid(rv0), .RespReady(rr0),
    .RespRData(rd0), .RespErr(er0), .Busy(bz0));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected response for a request, from the bench's own memory model.
  task automatic push_exp(input logic wr, input logic [15:0] addr, input logic [15:0] wd);
    logic err;
    err = addr[0] | (addr[15:8] != 8'h00);
    if (err) exp_q.push_back({1'b1, 16'h0000});
    else if (wr) begin
      model[int'(addr)] = wd;
      exp_q.push_back({1'b0, 16'h0000});
    end else exp_q.push_back({1'b0, model.exists(int'(addr)) ? model[int'(addr)] : 16'h0000});
  endtask

  task automatic sb_check(input string tag, input logic err, input logic [15:0] rdata);
    logic [16:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_err"}, {31'd0, err}, {31'd0, e[16]});
      check({tag, "_rdata"}, {16'd0, rdata}, {16'd0, e[15:0]});
    end
  endtask

  // One transaction on dut2; stall = cycles RespReady is held low in RESP (with a ReqValid pulse inside).
  task automatic txn2(input string tag, input logic wr, input logic [15:0] addr,
                      input logic [15:0] wd, input int stall);
    int cyc;
    logic [15:0] held;
    @(negedge clk);
    check({tag, "_ready_idle"}, {31'd0, rdy2}, 32'd1);
    v2 = 1; wr2 = wr; a2 = addr; wd2 = wd;
    push_exp(wr, addr, wd);
    @(negedge clk);
    v2 = 0;
    cyc = 1;
    while (!rv2 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, 32'd3);
    held = rd2;
    sb_check(tag, er2, rd2);
    for (int i = 0; i < stall; i++) begin
      v2 = (i == 2); wr2 = 1; a2 = 16'h0010; wd2 = 16'hDEAD;
      @(negedge clk);
      check({tag, "_stall_valid"}, {31'd0, rv2}, 32'd1);
      check({tag, "_stall_rdata"}, {16'd0, rd2}, {16'd0, held});
      check({tag, "_stall_ready"}, {31'd0, rdy2}, 32'd0);
    end
    // ReqValid together with the response handshake must not start a new transaction.
    v2 = (stall > 0); rr2 = 1;
    @(negedge clk);
    v2 = 0; rr2 = 0;
    check({tag, "_done_valid"}, {31'd0, rv2}, 32'd0);
    check({tag, "_done_busy"}, {31'd0, bz2}, 32'd0);
  endtask

  initial begin
    logic seen;
    logic [15:0] d0 [4];
    // Reset and idle
    #2;
    check("rst_ready_low", {31'd0, rdy2}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("idle_ready", {31'd0, rdy2}, 32'd1);
    check("idle_valid", {31'd0, rv2}, 32'd0);
    check("idle_rdata", {16'd0, rd2}, 32'd0);
    check("idle_err", {31'd0, er2}, 32'd0);
    check("idle_busy", {31'd0, bz2}, 32'd0);

    // Store then load, errors, stall
    txn2("st_beef", 1, 16'h0010, 16'hBEEF, 0);
    txn2("ld_beef", 0, 16'h0010, 16'h0000, 0);
    txn2("ld_misal", 0, 16'h0011, 16'h0000, 0);
    txn2("ld_range", 0, 16'h0100, 16'h0000, 0);
    txn2("st_misal", 1, 16'h0011, 16'h7777, 0);
    txn2("ld_again", 0, 16'h0010, 16'h0000, 0);
    txn2("ld_stall", 0, 16'h0010, 16'h0000, 5);
    txn2("ld_post", 0, 16'h0010, 16'h0000, 0);

    // Reset in WAIT aborts a store
    txn2("st_pre", 1, 16'h0020, 16'h5A5A, 0);
    @(negedge clk);
    v2 = 1; wr2 = 1; a2 = 16'h0020; wd2 = 16'h1234;
    @(negedge clk);
    v2 = 0;
    check("abort_busy_wait", {31'd0, bz2}, 32'd1);
    rst_n = 0;
    #1;
    check("abort_ready_rst", {31'd0, rdy2}, 32'd0);
    check("abort_busy_rst", {31'd0, bz2}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rv2) seen = 1;
    end
    check("abort_no_resp", {31'd0, seen}, 32'd0);
    txn2("ld_abort", 0, 16'h0020, 16'h0000, 0);

    // WAIT_CYCLES=0: back-to-back with ReqValid and RespReady held high
    for (int i = 0; i < 4; i++) d0[i] = 16'($urandom_range(0, 65535));
    @(negedge clk);
    rr0 = 1;
    for (int i = 0; i < 8; i++) begin
      check("b2b_ready", {31'd0, rdy0}, 32'd1);
      wr0 = (i < 4); a0 = 16'h0040 + 16'(2 * (i % 4)); wd0 = d0[i % 4]; v0 = 1;
      push_exp(wr0, a0, wd0);
      @(negedge clk);
      check("b2b_valid", {31'd0, rv0}, 32'd1);
      sb_check("b2b", er0, rd0);
      @(negedge clk);
      check("b2b_gap", {31'd0, rv0}, 32'd0);
    end
    v0 = 0; rr0 = 0;
    @(negedge clk);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
